// File: rtl/gaplus_pkg.sv
// Shared lane encodings, FSM states and sweep constants for the sprite RAM port.
`default_nettype none

package gaplus_pkg;

    typedef enum logic [1:0] {
        LANE0     = 2'd0,
        LANE1     = 2'd1,
        LANE2     = 2'd2,
        LANE_NONE = 2'd3
    } lane_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int         SWEEP_LEN    = 128;
    localparam logic [7:0] LANE3_RD_VAL = 8'hFF;
    localparam int         WQ_W         = 17;

endpackage

`default_nettype wire

// File: rtl/gaplus_spra_wfifo.sv
// CPU write queue: DEPTH-entry FIFO of {lane, index, data}; push at full only lands with a pop.
`default_nettype none

module gaplus_spra_wfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/gaplus_spra_port.sv
// Sprite RAM port: three 128x8 lanes shared by the scanner (top priority), CPU reads
// and a queued CPU write path, with a clearing sweep after reset.
`default_nettype none

module gaplus_spra_port
    import gaplus_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] CLR_VAL    = 8'h00
) (
    input  logic        VCLKx4,
    input  logic        RESET,
    input  logic [6:0]  SPRA_A,
    input  logic        SPRA_RE,
    output logic [23:0] SPRA_D,
    input  logic [8:0]  CPU_A,
    input  logic        CPU_WR,
    input  logic        CPU_RD,
    input  logic [7:0]  CPU_DI,
    output logic [7:0]  CPU_DO,
    output logic        CPU_ACK,
    output logic        CPU_BUSY,
    output logic        INIT_DONE,
    output logic        OVF
);

    state_e          state_q;
    logic [6:0]      sweep_q;
    logic            init_done_q;
    logic            ovf_q;
    logic            pend_q;
    logic [8:0]      rd_a_q;
    logic            ack_q;
    logic [7:0]      cpu_do_q;
    logic [23:0]     spra_d_q;

    logic            in_run;
    logic            scan_go;
    logic            rd_go;
    logic            q_pop;
    logic            q_push;
    logic            q_drop;
    logic            q_full;
    logic            q_empty;
    logic [WQ_W-1:0] q_data;
    logic [2:0][7:0] lane_rd;
    logic [7:0]      rd_byte;

    assign in_run  = (state_q == ST_RUN);
    assign scan_go = in_run & SPRA_RE;
    // Reads wait for an empty queue so they always observe earlier CPU writes.
    assign rd_go   = in_run & pend_q & q_empty & ~SPRA_RE;
    assign q_pop   = in_run & ~SPRA_RE & ~rd_go & ~q_empty;
    assign q_push  = in_run & CPU_WR;
    assign q_drop  = in_run & CPU_WR & q_full & ~q_pop;

    gaplus_spra_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WQ_W)
    ) u_wfifo (
        .clk_i   (VCLKx4),
        .rst_i   (RESET),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  ({CPU_A, CPU_DI}),
        .data_o  (q_data),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    for (genvar g = 0; g < 3; g++) begin : g_lane
        logic [7:0] mem_q [SWEEP_LEN];
        logic [6:0] addr;
        logic       we;
        logic [7:0] wd;

        always_comb begin
            we   = 1'b0;
            wd   = q_data[7:0];
            addr = q_data[14:8];
            if (!in_run) begin
                we   = 1'b1;
                wd   = CLR_VAL;
                addr = sweep_q;
            end else if (scan_go) begin
                addr = SPRA_A;
            end else if (rd_go) begin
                addr = rd_a_q[6:0];
            end else if (q_pop && (q_data[16:15] == 2'(g))) begin
                we = 1'b1;
            end
        end

        always_ff @(posedge VCLKx4) begin
            if (we) mem_q[addr] <= wd;
        end

        assign lane_rd[g] = mem_q[addr];
    end

    always_comb begin
        case (lane_e'(rd_a_q[8:7]))
            LANE0:   rd_byte = lane_rd[0];
            LANE1:   rd_byte = lane_rd[1];
            LANE2:   rd_byte = lane_rd[2];
            default: rd_byte = LANE3_RD_VAL;
        endcase
    end

    always_ff @(posedge VCLKx4 or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            rd_a_q      <= '0;
            ack_q       <= 1'b0;
            cpu_do_q    <= '0;
            spra_d_q    <= '0;
        end else begin
            ack_q <= rd_go;
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + 7'd1;
                    if (sweep_q == 7'(SWEEP_LEN - 1)) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                    if (CPU_WR || CPU_RD) ovf_q <= 1'b1;
                end
                ST_RUN: begin
                    if (q_drop) ovf_q <= 1'b1;
                    if (CPU_RD && !pend_q) begin
                        pend_q <= 1'b1;
                        rd_a_q <= CPU_A;
                    end else if (rd_go) begin
                        pend_q <= 1'b0;
                    end
                    if (scan_go) spra_d_q <= lane_rd;
                    if (rd_go)   cpu_do_q <= rd_byte;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign SPRA_D    = spra_d_q;
    assign CPU_DO    = cpu_do_q;
    assign CPU_ACK   = ack_q;
    assign INIT_DONE = init_done_q;
    assign OVF       = ovf_q;
    assign CPU_BUSY  = (state_q == ST_INIT) | q_full | pend_q;

endmodule

`default_nettype wire

// File: tb/tb_gaplus_spra_port.sv
// Scoreboard bench for gaplus_spra_port: expected scanner/CPU read data queued at issue, compared on output.
`default_nettype none

module tb_gaplus_spra_port;

    logic        clk;
    logic        rst;
    logic [6:0]  spra_a;
    logic        spra_re;
    logic [23:0] spra_d;
    logic [8:0]  cpu_a;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        cpu_ack;
    logic        cpu_busy;
    logic        init_done;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model [3][128];
    logic [23:0] scan_q [$];
    logic [7:0]  cpu_q  [$];
    logic        in_init = 1'b0;

    gaplus_spra_port #(
        .FIFO_DEPTH (4),
        .CLR_VAL    (8'h00)
    ) dut (
        .VCLKx4    (clk),
        .RESET     (rst),
        .SPRA_A    (spra_a),
        .SPRA_RE   (spra_re),
        .SPRA_D    (spra_d),
        .CPU_A     (cpu_a),
        .CPU_WR    (cpu_wr),
        .CPU_RD    (cpu_rd),
        .CPU_DI    (cpu_di),
        .CPU_DO    (cpu_do),
        .CPU_ACK   (cpu_ack),
        .CPU_BUSY  (cpu_busy),
        .INIT_DONE (init_done),
        .OVF       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 128; i++)
                model[l][i] = 8'h00;
    endtask

    task automatic cpu_write(input logic [1:0] lane, input logic [6:0] idx,
                             input logic [7:0] d, input bit lands);
        cpu_wr = 1'b1;
        cpu_a  = {lane, idx};
        cpu_di = d;
        if (lands && lane != 2'd3) model[lane][idx] = d;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] lane, input logic [6:0] idx);
        cpu_rd = 1'b1;
        cpu_a  = {lane, idx};
        cpu_q.push_back(lane == 2'd3 ? 8'hFF : model[lane][idx]);
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic scan_read(input logic [6:0] a);
        spra_re = 1'b1;
        spra_a  = a;
        tick();
        spra_re = 1'b0;
    endtask

    task automatic wait_init(input string tag, input int start);
        int n;
        n = start;
        while (n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (init_done) break;
        end
        chk_eq(tag, n, 128);
    endtask

    task automatic wait_cpu_drain(input string tag);
        for (int i = 0; i < 40 && cpu_q.size() != 0; i++) tick();
        chk_eq(tag, cpu_q.size(), 0);
    endtask

    // Monitor: scanner data one cycle after each sampled strobe; CPU data on every ack.
    initial begin
        logic        sre;
        logic [6:0]  sa;
        logic [23:0] e24;
        logic [7:0]  e8;
        forever begin
            @(posedge clk);
            sre = spra_re;
            sa  = spra_a;
            if (sre && !rst)
                scan_q.push_back(in_init ? 24'h0 : {model[2][sa], model[1][sa], model[0][sa]});
            #2;
            if (scan_q.size() != 0) begin
                e24 = scan_q.pop_front();
                chk_eq("spra_d", spra_d, e24);
            end
            if (cpu_ack === 1'b1) begin
                if (cpu_q.size() == 0) begin
                    chk_eq("ack_unexpected", cpu_ack, 1'b0);
                end else begin
                    e8 = cpu_q.pop_front();
                    chk_eq("cpu_do", cpu_do, e8);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; spra_a = '0; spra_re = 1'b0;
        cpu_a = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_di = '0;
        model_clear();
        repeat (3) tick();
        chk_eq("rst_init_done", init_done, 1'b0);
        chk_eq("rst_busy", cpu_busy, 1'b1);
        chk_eq("rst_ovf", ovf, 1'b0);
        chk_eq("rst_spra_d", spra_d, 24'h0);
        chk_eq("rst_ack", cpu_ack, 1'b0);
        chk_eq("rst_cpu_do", cpu_do, 8'h00);

        rst = 1'b0;
        wait_init("init_cycles", 0);
        chk_eq("run_busy", cpu_busy, 1'b0);

        scan_read(7'h00);
        scan_read(7'h7F);

        cpu_write(2'd0, 7'd5, 8'h12, 1'b1);
        cpu_write(2'd1, 7'd5, 8'h34, 1'b1);
        cpu_write(2'd2, 7'd5, 8'h56, 1'b1);
        repeat (4) tick();
        scan_read(7'd5);
        tick();
        chk_eq("lane_pack", {model[2][5], model[1][5], model[0][5]}, 24'h563412);

        // Scanner hogs the lanes: queue fills, the fifth write is dropped.
        spra_re = 1'b1;
        spra_a  = 7'h40;
        for (int i = 0; i < 4; i++)
            cpu_write(2'(i % 3), 7'(20 + i), 8'(8'hC0 + i), 1'b1);
        chk_eq("full_busy", cpu_busy, 1'b1);
        chk_eq("ovf_pre", ovf, 1'b0);
        cpu_write(2'd0, 7'd24, 8'hEE, 1'b0);
        chk_eq("ovf_drop", ovf, 1'b1);
        spra_re = 1'b0;
        repeat (4) tick();
        for (int i = 20; i <= 24; i++) scan_read(7'(i));

        cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_a = {2'd1, 7'd9}; cpu_di = 8'hA5;
        model[1][9] = 8'hA5;
        cpu_q.push_back(8'hA5);
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        wait_cpu_drain("wr_rd_ack");
        repeat (3) tick();

        // Second read while one is pending must be ignored.
        spra_re = 1'b1; spra_a = 7'h10;
        cpu_read(2'd0, 7'd5);
        cpu_rd = 1'b1; cpu_a = {2'd1, 7'd5};
        tick();
        cpu_rd = 1'b0;
        chk_eq("pend_busy", cpu_busy, 1'b1);
        spra_re = 1'b0;
        wait_cpu_drain("pend_ack");
        repeat (3) tick();

        cpu_read(2'd2, 7'd21);
        wait_cpu_drain("lane2_ack");
        cpu_write(2'd3, 7'd5, 8'h77, 1'b1);
        repeat (2) tick();
        cpu_read(2'd3, 7'd5);
        wait_cpu_drain("lane3_ack");
        scan_read(7'd5);
        repeat (2) tick();

        // Reset during the sweep at index 60, then init-phase accesses.
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (60) tick();
        rst = 1'b1;
        #1;
        chk_eq("mid_rst_ovf", ovf, 1'b0);
        chk_eq("mid_rst_done", init_done, 1'b0);
        tick();
        rst = 1'b0;
        model_clear();
        in_init = 1'b1;
        spra_re = 1'b1; spra_a = 7'd5;
        cpu_wr = 1'b1; cpu_a = {2'd0, 7'd1}; cpu_di = 8'h99;
        tick();
        spra_re = 1'b0; cpu_wr = 1'b0;
        chk_eq("init_ovf", ovf, 1'b1);
        chk_eq("init_busy", cpu_busy, 1'b1);
        in_init = 1'b0;
        wait_init("reinit_cycles", 1);
        scan_read(7'd5);
        scan_read(7'd1);
        repeat (3) tick();

        chk_eq("scan_left", scan_q.size(), 0);
        chk_eq("cpu_left", cpu_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gaplus_spra_port.md
GAPLUS_SPRA_PORT -- requirements
Module: gaplus_spra_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, setting CPU write-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter CLR_VAL, default 8'h00, setting the byte written to every RAM location during the init sweep.
REQ-003 VCLKx4  in  1  sole clock; the sprite scanner clock. One clock; reset is asynchronous and active-high.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 SPRA_A  in  7  scanner read address {entry[5:0], word}.
REQ-006 SPRA_RE  in  1  scanner read strobe.
REQ-007 SPRA_D  out  24  scanner read data {lane2, lane1, lane0}.
REQ-008 CPU_A  in  9  CPU address {lane[1:0], index[6:0]}.
REQ-009 CPU_WR  in  1  single-cycle CPU write strobe.
REQ-010 CPU_RD  in  1  single-cycle CPU read request.
REQ-011 CPU_DI  in  8  CPU write data.
REQ-012 CPU_DO  out  8  CPU read data.
REQ-013 CPU_ACK  out  1  one-cycle pulse marking CPU_DO valid.
REQ-014 CPU_BUSY  out  1  high while initialising, write queue full, or a CPU read is pending.
REQ-015 INIT_DONE  out  1  high once the clear sweep has finished.
REQ-016 OVF  out  1  sticky flag: a CPU write was dropped.

Function
REQ-017 Storage SHALL be three single-port 128x8 lanes addressed by index; each lane performs at most one access per cycle.
REQ-018 FSM states SHALL be INIT, RUN. INIT writes CLR_VAL to index 0..127 in all lanes, one index per cycle (128 cycles), then goes to RUN and raises INIT_DONE.
REQ-019 In INIT, SPRA_RE SHALL be ignored (SPRA_D holds 0), and CPU_WR/CPU_RD SHALL be ignored and set OVF.
REQ-020 Per-cycle RAM port priority in RUN SHALL be: scanner read > CPU read > write-queue drain.
REQ-021 A scanner read SHALL return SPRA_D registered one cycle after SPRA_RE; SPRA_D holds its value until the next read.
REQ-022 CPU_WR SHALL enqueue {CPU_A, CPU_DI}. If the queue is full, the write SHALL be dropped and OVF set. Simultaneous enqueue and dequeue at full SHALL succeed.
REQ-023 The queue SHALL dequeue one entry in any RUN cycle with no scanner read and no CPU read granted; the entry's lane is written at its index.
REQ-024 A CPU_RD SHALL be held pending until the queue is empty (read-after-write coherence). It is then granted in the first cycle without SPRA_RE, and CPU_ACK and CPU_DO follow one cycle after the grant.
REQ-025 CPU_RD while a read is already pending SHALL be ignored.
REQ-026 Lane 3 writes SHALL be discarded without error, and lane 3 reads SHALL ack with 8'hFF.
REQ-027 A simultaneous CPU_WR and CPU_RD SHALL enqueue the write first; the read then returns the new data.
REQ-028 CPU_BUSY SHALL be combinational from state, the queue-full flag and the pending flag.
REQ-029 Queue pointers SHALL wrap modulo FIFO_DEPTH, with count width clog2(FIFO_DEPTH)+1.

Reset
REQ-030 On RESET: state=INIT, sweep index=0, queue empty, no read pending, SPRA_D=0, CPU_DO=0, CPU_ACK=0, INIT_DONE=0, OVF=0, CPU_BUSY=1.
REQ-031 RESET asserted mid-sweep or mid-operation SHALL discard queued writes and pending reads, and restart the sweep at index 0.

Structure
REQ-032 Package gaplus_pkg SHALL hold the lane encodings (LANE0..LANE2, LANE_NONE=3), the sweep length 128, and the lane-3 read value 8'hFF.
REQ-033 The write queue SHALL be sub-module gaplus_spra_wfifo (parameter DEPTH; push, pop, full, empty, data 17 bits).
REQ-034 The lanes SHALL be inferred RAM, with no vendor primitives.

Verification
REQ-035 Reset, then 128 cycles -> INIT_DONE rises at cycle 128; scanner reads of 0x00 and 0x7F return 24'h000000.
REQ-036 CPU writes 0x12 to lane0 idx 5, 0x34 to lane1 idx 5, 0x56 to lane2 idx 5; after drain, SPRA_RE with A=5 -> SPRA_D=24'h563412 the next cycle.
REQ-037 SPRA_RE held high continuously while 4 writes are issued -> queue fills, CPU_BUSY=1, a 5th write sets OVF; after SPRA_RE drops, all 4 writes land within 4 cycles.
REQ-038 CPU_WR and CPU_RD together to lane1 idx 9 with data 0xA5 -> CPU_ACK pulses once with CPU_DO=0xA5.
REQ-039 CPU_RD of lane 3 -> CPU_ACK with 8'hFF. RESET mid-sweep at index 60 -> the sweep restarts and INIT_DONE rises 128 cycles after release.
